// File: rtl/fmm_reduce_pkg.sv
// Shared types and defaults for the row-pair column-reduce scheduler.
package fmm_reduce_pkg;

  localparam int unsigned ADDR_W_DEF = 17;
  localparam int unsigned ROW_W_DEF  = 16;

  typedef logic [ADDR_W_DEF-1:0] addr_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_ISSUE,
    S_WAIT,
    S_ADVANCE,
    S_FINISH
  } sched_state_t;

endpackage

// File: rtl/fmm_reduce_base_gen.sv
// Row-base accumulators for the reduce loop: source pair (2k, 2k+1) and destination row k.
module fmm_reduce_base_gen #(
  parameter int unsigned ADDR_W = 17
) (
  input  logic              ap_clk,
  input  logic              ap_rst,
  input  logic              load,
  input  logic              advance,
  input  logic [ADDR_W-1:0] n_cols,
  input  logic [ADDR_W-1:0] dst_base,
  output logic [ADDR_W-1:0] base_a,
  output logic [ADDR_W-1:0] base_b,
  output logic [ADDR_W-1:0] base_dst
);

  logic [ADDR_W-1:0] step2;
  logic [ADDR_W-1:0] row_len;

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      base_a   <= '0;
      base_b   <= '0;
      base_dst <= '0;
      step2    <= '0;
      row_len  <= '0;
    end else if (load) begin
      base_a   <= '0;
      base_b   <= n_cols;
      base_dst <= dst_base;
      step2    <= {n_cols[ADDR_W-2:0], 1'b0};
      row_len  <= n_cols;
    end else if (advance) begin
      // All sums wrap modulo 2^ADDR_W by construction of the register width.
      base_a   <= base_a + step2;
      base_b   <= base_b + step2;
      base_dst <= base_dst + row_len;
    end
  end

endmodule

// File: rtl/fmm_reduce_row_pair_scheduler.sv
// Walks the M_e row pairs, launching the pipelined column-reduce loop once per pair (ap_ctrl_hs both sides).
module fmm_reduce_row_pair_scheduler
  import fmm_reduce_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned ROW_W  = ROW_W_DEF
) (
  input  logic              ap_clk,
  input  logic              ap_rst,
  input  logic              ap_start,
  output logic              ap_done,
  output logic              ap_idle,
  output logic              ap_ready,
  input  logic [ROW_W-1:0]  cfg_n_rows,
  input  logic [31:0]       cfg_n_cols,
  input  logic [ADDR_W-1:0] cfg_dst_base,
  input  logic              cfg_match_en,
  input  logic              cfg_neg_en,
  output logic              loop_ap_start,
  input  logic              loop_ap_ready,
  input  logic              loop_ap_done,
  output logic [31:0]       loop_new_col,
  output logic [ADDR_W-1:0] loop_base_a,
  output logic [ADDR_W-1:0] loop_base_b,
  output logic [ADDR_W-1:0] loop_base_dst,
  output logic              loop_flag_match,
  output logic              loop_flag_neg,
  output logic [ROW_W-1:0]  pair_count
);

  sched_state_t      state;
  logic [ROW_W-1:0]  n_rows_q;
  logic [ADDR_W-1:0] dst_base_q;
  logic [ROW_W-1:0]  npairs;
  logic [ROW_W-1:0]  pair_next;
  logic              no_work;

  assign npairs    = n_rows_q >> 1;
  assign pair_next = pair_count + ROW_W'(1);
  // loop_new_col doubles as the latched column count; non-positive counts skip the loop.
  assign no_work   = (npairs == '0) || loop_new_col[31] || (loop_new_col == '0);

  fmm_reduce_base_gen #(
    .ADDR_W (ADDR_W)
  ) u_base_gen (
    .ap_clk   (ap_clk),
    .ap_rst   (ap_rst),
    .load     (state == S_SETUP),
    .advance  (state == S_ADVANCE),
    .n_cols   (loop_new_col[ADDR_W-1:0]),
    .dst_base (dst_base_q),
    .base_a   (loop_base_a),
    .base_b   (loop_base_b),
    .base_dst (loop_base_dst)
  );

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state           <= S_IDLE;
      ap_idle         <= 1'b1;
      ap_done         <= 1'b0;
      ap_ready        <= 1'b0;
      loop_ap_start   <= 1'b0;
      pair_count      <= '0;
      n_rows_q        <= '0;
      dst_base_q      <= '0;
      loop_new_col    <= '0;
      loop_flag_match <= 1'b0;
      loop_flag_neg   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (ap_start) begin
            n_rows_q        <= cfg_n_rows;
            loop_new_col    <= cfg_n_cols;
            dst_base_q      <= cfg_dst_base;
            loop_flag_match <= cfg_match_en;
            loop_flag_neg   <= cfg_neg_en;
            pair_count      <= '0;
            ap_idle         <= 1'b0;
            state           <= S_SETUP;
          end
        end
        S_SETUP: begin
          if (no_work) begin
            ap_done  <= 1'b1;
            ap_ready <= 1'b1;
            state    <= S_FINISH;
          end else begin
            loop_ap_start <= 1'b1;
            state         <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (loop_ap_ready) begin
            loop_ap_start <= 1'b0;
            state         <= loop_ap_done ? S_ADVANCE : S_WAIT;
          end
        end
        S_WAIT: begin
          if (loop_ap_done) state <= S_ADVANCE;
        end
        S_ADVANCE: begin
          pair_count <= pair_next;
          if (pair_next == npairs) begin
            ap_done  <= 1'b1;
            ap_ready <= 1'b1;
            state    <= S_FINISH;
          end else begin
            loop_ap_start <= 1'b1;
            state         <= S_ISSUE;
          end
        end
        S_FINISH: begin
          ap_done  <= 1'b0;
          ap_ready <= 1'b0;
          ap_idle  <= 1'b1;
          state    <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fmm_reduce_row_pair_scheduler.sv
// Directed bench for the row-pair scheduler with a simple ap_ctrl_hs child model.
module tb_fmm_reduce_row_pair_scheduler;

  localparam int unsigned ADDR_W = 17;
  localparam int unsigned ROW_W  = 16;

  logic              ap_clk = 1'b0;
  logic              ap_rst;
  logic              ap_start;
  logic              ap_done, ap_idle, ap_ready;
  logic [ROW_W-1:0]  cfg_n_rows;
  logic [31:0]       cfg_n_cols;
  logic [ADDR_W-1:0] cfg_dst_base;
  logic              cfg_match_en, cfg_neg_en;
  logic              loop_ap_start;
  logic              loop_ap_ready, loop_ap_done;
  logic [31:0]       loop_new_col;
  logic [ADDR_W-1:0] loop_base_a, loop_base_b, loop_base_dst;
  logic              loop_flag_match, loop_flag_neg;
  logic [ROW_W-1:0]  pair_count;

  always #5 ap_clk = ~ap_clk;

  fmm_reduce_row_pair_scheduler #(
    .ADDR_W (ADDR_W),
    .ROW_W  (ROW_W)
  ) dut (
    .ap_clk          (ap_clk),
    .ap_rst          (ap_rst),
    .ap_start        (ap_start),
    .ap_done         (ap_done),
    .ap_idle         (ap_idle),
    .ap_ready        (ap_ready),
    .cfg_n_rows      (cfg_n_rows),
    .cfg_n_cols      (cfg_n_cols),
    .cfg_dst_base    (cfg_dst_base),
    .cfg_match_en    (cfg_match_en),
    .cfg_neg_en      (cfg_neg_en),
    .loop_ap_start   (loop_ap_start),
    .loop_ap_ready   (loop_ap_ready),
    .loop_ap_done    (loop_ap_done),
    .loop_new_col    (loop_new_col),
    .loop_base_a     (loop_base_a),
    .loop_base_b     (loop_base_b),
    .loop_base_dst   (loop_base_dst),
    .loop_flag_match (loop_flag_match),
    .loop_flag_neg   (loop_flag_neg),
    .pair_count      (pair_count)
  );

  int n_compared   = 0;
  int n_mismatched = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Child model and monitor, evaluated on the falling edge.
  int rdy_lat = 0, done_lat = 0;
  int cyc = 0, n_launch = 0, done_pulses = 0, done_cyc = 0;
  int drop_err = 0, ready_err = 0;
  int rcnt = 0, dcnt = 0;
  bit busy = 0, prev_hs = 0;
  logic [ADDR_W-1:0] l_a[8], l_b[8], l_d[8];
  logic [31:0]       l_col[8];
  logic              l_fm[8], l_fn[8];

  initial begin
    loop_ap_ready = 1'b0;
    loop_ap_done  = 1'b0;
    forever begin
      @(negedge ap_clk);
      cyc++;
      if (ap_done) begin
        done_pulses++;
        done_cyc = cyc;
      end
      if (ap_ready !== ap_done) ready_err++;
      if (prev_hs && loop_ap_start) drop_err++;
      prev_hs       = 0;
      loop_ap_ready = 1'b0;
      loop_ap_done  = 1'b0;
      if (busy) begin
        if (dcnt == done_lat) begin
          loop_ap_done = 1'b1;
          busy = 0;
        end else dcnt++;
      end else if (loop_ap_start) begin
        if (rcnt == rdy_lat) begin
          loop_ap_ready = 1'b1;
          prev_hs = 1;
          rcnt = 0;
          if (n_launch < 8) begin
            l_a[n_launch]   = loop_base_a;
            l_b[n_launch]   = loop_base_b;
            l_d[n_launch]   = loop_base_dst;
            l_col[n_launch] = loop_new_col;
            l_fm[n_launch]  = loop_flag_match;
            l_fn[n_launch]  = loop_flag_neg;
          end
          n_launch++;
          if (done_lat == 0) loop_ap_done = 1'b1;
          else begin
            busy = 1;
            dcnt = 1;
          end
        end else rcnt++;
      end
    end
  end

  typedef struct {
    int n_rows; int n_cols; int dst; bit fm; bit fn;
    int rdy; int dn;
    int exp_launch; int exp_pc; int exp_lat;
    int a0; int b0; int d0; int a1; int b1; int d1;
  } vec_t;

  task automatic tick(input int n);
    repeat (n) @(negedge ap_clk);
    #1;
  endtask

  // Launch one run; cfg inputs are scrambled right after the start is taken.
  task automatic start_run(input vec_t v, input int t0_dummy, output int t0);
    n_launch = 0; done_pulses = 0; drop_err = 0; ready_err = 0;
    rdy_lat = v.rdy; done_lat = v.dn;
    cfg_n_rows   = ROW_W'(v.n_rows);
    cfg_n_cols   = 32'(v.n_cols);
    cfg_dst_base = ADDR_W'(v.dst);
    cfg_match_en = v.fm;
    cfg_neg_en   = v.fn;
    ap_start     = 1'b1;
    t0 = cyc + t0_dummy;
    tick(1);
    ap_start     = 1'b0;
    cfg_n_rows   = 16'hFFFF;
    cfg_n_cols   = 32'd999;
    cfg_dst_base = 17'h1555;
    cfg_match_en = ~v.fm;
    cfg_neg_en   = ~v.fn;
  endtask

  task automatic wait_done(input string name);
    int budget;
    budget = 0;
    while (done_pulses == 0 && budget < 500) begin
      tick(1);
      budget++;
    end
    if (done_pulses == 0) begin
      n_compared++;
      n_mismatched++;
      $display("FAIL %s_timeout: got no ap_done expected one within 500 cycles", name);
    end
  endtask

  task automatic run_vec(input vec_t v, input string name);
    int t0;
    start_run(v, 0, t0);
    wait_done(name);
    tick(2);
    chk({name, "_done_pulses"}, done_pulses, 1);
    chk({name, "_launches"}, n_launch, v.exp_launch);
    chk({name, "_pair_count"}, pair_count, v.exp_pc);
    chk({name, "_idle"}, ap_idle, 1);
    chk({name, "_ready_eq_done"}, ready_err, 0);
    chk({name, "_start_drop"}, drop_err, 0);
    if (v.exp_lat != 0) chk({name, "_done_latency"}, done_cyc - t0, v.exp_lat);
    if (v.exp_launch > 0 && v.exp_launch <= 8) begin
      chk({name, "_a_first"}, l_a[0], v.a0);
      chk({name, "_b_first"}, l_b[0], v.b0);
      chk({name, "_dst_first"}, l_d[0], v.d0);
      chk({name, "_col"}, l_col[0], 32'(v.n_cols));
      chk({name, "_flag_match"}, l_fm[0], v.fm);
      chk({name, "_flag_neg"}, l_fn[0], v.fn);
      chk({name, "_a_last"}, l_a[v.exp_launch-1], v.a1);
      chk({name, "_b_last"}, l_b[v.exp_launch-1], v.b1);
      chk({name, "_dst_last"}, l_d[v.exp_launch-1], v.d1);
    end
  endtask

  vec_t vecs[8];

  initial begin
    int t0;
    vec_t v;
    //           rows cols   dst     fm fn rdy dn  L  pc lat  a0 b0    d0      a1    b1     d1
    vecs[0] = '{4,   10,    40,     1, 0, 3,  0,  2, 2, 0,   0, 10,   40,     20,   30,    50};
    vecs[1] = '{5,   8,     100,    0, 1, 1,  2,  2, 2, 0,   0, 8,    100,    16,   24,    108};
    vecs[2] = '{1,   10,    5,      1, 1, 0,  0,  0, 0, 2,   0, 0,    0,      0,    0,     0};
    vecs[3] = '{4,   0,     5,      0, 0, 0,  0,  0, 0, 2,   0, 0,    0,      0,    0,     0};
    vecs[4] = '{4,   -3,    5,      0, 0, 0,  0,  0, 0, 2,   0, 0,    0,      0,    0,     0};
    vecs[5] = '{2,   5,     7,      1, 1, 1,  20, 1, 1, 0,   0, 5,    7,      0,    5,     7};
    vecs[6] = '{6,   3,     0,      0, 1, 0,  0,  3, 3, 0,   0, 3,    0,      12,   15,    6};
    vecs[7] = '{4,   70000, 131056, 1, 0, 2,  1,  2, 2, 0,   0, 70000, 131056, 8928, 78928, 69984};

    ap_rst = 1'b1; ap_start = 1'b0;
    cfg_n_rows = '0; cfg_n_cols = '0; cfg_dst_base = '0;
    cfg_match_en = 1'b0; cfg_neg_en = 1'b0;
    tick(3);
    chk("rst_idle", ap_idle, 1);
    chk("rst_done", ap_done, 0);
    chk("rst_ready", ap_ready, 0);
    chk("rst_loop_start", loop_ap_start, 0);
    chk("rst_pair_count", pair_count, 0);
    chk("rst_base_a", loop_base_a, 0);
    chk("rst_base_b", loop_base_b, 0);
    chk("rst_base_dst", loop_base_dst, 0);
    chk("rst_new_col", loop_new_col, 0);
    chk("rst_flags", {loop_flag_match, loop_flag_neg}, 0);
    ap_rst = 1'b0;
    tick(1);

    for (int i = 0; i < 8; i++) begin
      run_vec(vecs[i], $sformatf("vec%0d", i));
      tick(1);
    end

    // Reset while the child is busy (scheduler in WAIT).
    v = vecs[5];
    v.n_rows = 4; v.n_cols = 10; v.dst = 40;
    start_run(v, 0, t0);
    tick(6);
    chk("rstmid_launched", n_launch, 1);
    chk("rstmid_not_idle", ap_idle, 0);
    ap_rst = 1'b1;
    @(posedge ap_clk);
    #1;
    chk("rstmid_idle", ap_idle, 1);
    chk("rstmid_loop_start", loop_ap_start, 0);
    chk("rstmid_pair_count", pair_count, 0);
    ap_rst = 1'b0;
    tick(30);
    chk("rstmid_spurious_ignored", ap_idle, 1);
    chk("rstmid_no_launch", n_launch, 1);
    run_vec(vecs[0], "after_rst");
    tick(1);

    // ap_start held high across FINISH re-launches with the same config.
    v = vecs[6];
    v.n_rows = 4; v.n_cols = 2; v.dst = 0;
    n_launch = 0; done_pulses = 0; rdy_lat = 0; done_lat = 0;
    cfg_n_rows = 16'd4; cfg_n_cols = 32'd2; cfg_dst_base = '0;
    cfg_match_en = 1'b0; cfg_neg_en = 1'b0;
    ap_start = 1'b1;
    wait_done("hold1");
    chk("hold_launches_run1", n_launch, 2);
    tick(1);
    chk("hold_idle_gap", ap_idle, 1);
    tick(1);
    chk("hold_restarted", ap_idle, 0);
    ap_start = 1'b0;
    done_pulses = 0;
    wait_done("hold2");
    tick(2);
    chk("hold_launches_total", n_launch, 4);
    chk("hold_pair_count", pair_count, 2);
    chk("hold_second_bases", {l_a[3], l_b[3], l_d[3]}, {17'd4, 17'd6, 17'd2});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
